// File: rtl/display_pkg.sv
// Shared types and constants for the serial display driver.
package display_pkg;
  localparam int FRAME_BITS      = 160;
  localparam int CLK_DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    LATCH
  } state_t;
endpackage

// File: rtl/display_shift_driver_clk_div.sv
// Serial-clock half-period tick: one-cycle pulse every CLK_DIV cycles, sync clear to zero.
// Latency: tick asserted combinationally on the terminal count; no backpressure.
module display_clk_div
  import display_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  logic [7:0] cnt_q, cnt_d;

  assign tick = (cnt_q == 8'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_shift_driver.sv
// Snapshots {sevseg, screen} and shifts the 160-bit frame MSB-first, 322*CLK_DIV cycles per frame.
// Requests while busy coalesce into one back-to-back frame; DISPLAY_AUTO_REFRESH_EN adds a periodic self-update.
module display_shift_driver
  import display_pkg::*;
#(
  parameter int CLK_DIV        = CLK_DIV_DEFAULT,
  parameter int REFRESH_PERIOD = 50000000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] screen_data,
  input  logic [31:0]  sevseg_data,
  input  logic         update,
  output logic         ser_clk,
  output logic         ser_data,
  output logic         ser_cs_n,
  output logic         ser_latch,
  output logic         busy,
  output logic [15:0]  frame_count
);

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [7:0]            bit_cnt_q, bit_cnt_d;
  logic                  phase_q, phase_d;
  logic                  pending_q, pending_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic                  tick;
  logic                  req;

`ifdef DISPLAY_AUTO_REFRESH_EN
  logic [31:0] refresh_cnt_q, refresh_cnt_d;
  logic        auto_upd;

  assign auto_upd = (refresh_cnt_q == 32'(REFRESH_PERIOD - 1));
  assign req      = update | auto_upd;

  always_comb begin
    refresh_cnt_d = refresh_cnt_q + 32'd1;
    if (auto_upd) refresh_cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) refresh_cnt_q <= '0;
    else       refresh_cnt_q <= refresh_cnt_d;
  end
`else
  assign req = update;
`endif

  // Divider is held at zero in IDLE so every frame starts phase-aligned.
  display_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clock (clock),
    .reset (reset),
    .clr   (state_q == IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    bit_cnt_d     = bit_cnt_q;
    phase_d       = phase_q;
    pending_d     = pending_q;
    frame_count_d = frame_count_q;

    if (state_q != IDLE && req) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (req) begin
          frame_d   = {sevseg_data, screen_data};
          bit_cnt_d = '0;
          phase_d   = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
            if (bit_cnt_q == 8'(FRAME_BITS - 1)) state_d = LATCH;
            else                                 bit_cnt_d = bit_cnt_q + 8'd1;
          end
        end
      end
      LATCH: begin
        if (tick) begin
          frame_count_d = frame_count_q + 16'd1;
          // A request arriving on the final latch cycle also counts as pending.
          if (pending_q || req) begin
            pending_d = 1'b0;
            frame_d   = {sevseg_data, screen_data};
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            state_d   = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      frame_q       <= '0;
      bit_cnt_q     <= '0;
      phase_q       <= 1'b0;
      pending_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      bit_cnt_q     <= bit_cnt_d;
      phase_q       <= phase_d;
      pending_q     <= pending_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign ser_cs_n    = (state_q == IDLE) || (state_q == LATCH);
  assign ser_clk     = (state_q == SHIFT) && phase_q;
  assign ser_data    = ((state_q == SETUP) || (state_q == SHIFT)) ? frame_q[FRAME_BITS-1] : 1'b0;
  assign ser_latch   = (state_q == LATCH);
  assign busy        = (state_q != IDLE);
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_display_shift_driver.sv
// Randomized bench: a link-level monitor rebuilds each transmitted word and busy window for comparison.
module tb_display_shift_driver;

  localparam int CD = 4;
  localparam int RP = 2000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] screen_data = '0;
  logic [31:0]  sevseg_data = '0;
  logic         update = 1'b0;
  logic         b_update = 1'b0;
  logic         ser_clk, ser_data, ser_cs_n, ser_latch, busy;
  logic [15:0]  frame_count;
  logic         b_ser_clk, b_ser_data, b_ser_cs_n, b_ser_latch, b_busy;
  logic [15:0]  b_frame_count;

  int errors = 0;
  int checks = 0;

  logic [159:0] got_q[$];
  int           bits_q[$];
  int           unst_q[$];
  int           len_q[$];
  logic [159:0] exp_q[$];
  int           exp_len_q[$];
  logic [15:0]  fc_model = '0;

  logic [159:0] sh;
  int           nb, blen, unst;
  logic         p_clk, p_busy, p_latch, p_csn, low_bit;

  always #5 clk = ~clk;

  display_shift_driver #(.CLK_DIV(CD), .REFRESH_PERIOD(RP)) dut (
    .clock(clk), .reset(reset), .screen_data(screen_data), .sevseg_data(sevseg_data),
    .update(update), .ser_clk(ser_clk), .ser_data(ser_data), .ser_cs_n(ser_cs_n),
    .ser_latch(ser_latch), .busy(busy), .frame_count(frame_count)
  );

  display_shift_driver #(.CLK_DIV(1), .REFRESH_PERIOD(RP)) dut_b (
    .clock(clk), .reset(reset), .screen_data(screen_data), .sevseg_data(sevseg_data),
    .update(b_update), .ser_clk(b_ser_clk), .ser_data(b_ser_data), .ser_cs_n(b_ser_cs_n),
    .ser_latch(b_ser_latch), .busy(b_busy), .frame_count(b_frame_count)
  );

  // Link monitor: bits captured on ser_clk rising edges, data must hold for the whole bit.
  always @(negedge clk) begin
    if (reset) begin
      nb = 0; blen = 0; unst = 0; sh = '0;
      p_clk = 1'b0; p_busy = 1'b0; p_latch = 1'b0; p_csn = 1'b1; low_bit = 1'b0;
    end else begin
      if (busy) blen++;
      if (!ser_cs_n) begin
        if (!ser_clk) begin
          if (p_clk || p_csn) low_bit = ser_data;
          else if (ser_data !== low_bit) unst++;
        end else begin
          if (ser_data !== low_bit) unst++;
          if (!p_clk) begin
            sh = {sh[158:0], ser_data};
            nb++;
          end
        end
      end
      if (ser_latch && !p_latch) begin
        got_q.push_back(sh);
        bits_q.push_back(nb);
        unst_q.push_back(unst);
        nb = 0; unst = 0;
      end
      if (!busy && p_busy) begin
        len_q.push_back(blen);
        blen = 0;
      end
      p_clk = ser_clk; p_busy = busy; p_latch = ser_latch; p_csn = ser_cs_n;
    end
  end

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse();
    update = 1'b1;
    cyc();
    update = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy && n < 6000) begin
      cyc();
      n++;
    end
    if (busy) chk("timeout_busy", busy, 0);
  endtask

  task automatic verify_frames();
    logic [159:0] g, e;
    int b, u, l, el;
    chk("nframes", got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '0; b = 0; u = 0;
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        b = bits_q.pop_front();
        u = unst_q.pop_front();
      end
      chk("frame_word", g, e);
      chk("frame_bits", b, 160);
      chk("bit_stable", u, 0);
    end
    chk("nbusy", len_q.size(), exp_len_q.size());
    while (exp_len_q.size() > 0) begin
      el = exp_len_q.pop_front();
      l = (len_q.size() > 0) ? len_q.pop_front() : 0;
      chk("busy_len", l, el);
    end
    chk("frame_count", frame_count, fc_model);
    got_q.delete(); bits_q.delete(); unst_q.delete(); len_q.delete();
  endtask

  // One requested frame, optionally garbling inputs mid-frame and issuing npend coalescing requests.
  task automatic do_frame(input logic [31:0] sv0, input logic [127:0] sc0, input int npend, input bit garble);
    sevseg_data = sv0;
    screen_data = sc0;
    pulse();
    exp_q.push_back({sv0, sc0});
    fc_model++;
    repeat ($urandom_range(20, 400)) cyc();
    if (garble) screen_data = '1;
    for (int p = 0; p < npend; p++) begin
      sevseg_data = $urandom;
      screen_data = {$urandom, $urandom, $urandom, $urandom};
      pulse();
      repeat ($urandom_range(2, 60)) cyc();
    end
    if (npend > 0) begin
      exp_q.push_back({sevseg_data, screen_data});
      fc_model++;
      exp_len_q.push_back(644 * CD);
    end else begin
      exp_len_q.push_back(322 * CD);
    end
    wait_done();
    verify_frames();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    update = 1'b1;
    b_update = 1'b1;
    sevseg_data = $urandom;
    screen_data = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) cyc();
    chk("rst_cs_n", ser_cs_n, 1);
    chk("rst_clk", ser_clk, 0);
    chk("rst_data", ser_data, 0);
    chk("rst_latch", ser_latch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fc", frame_count, 0);
    update = 1'b0;
    b_update = 1'b0;
    reset = 1'b0;

`ifdef DISPLAY_AUTO_REFRESH_EN
    n = 0;
    while (!busy && n < 5000) begin
      cyc();
      n++;
    end
    chk("auto_first", n, RP);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (busy && n < 5000) begin
        cyc();
        n++;
      end
      while (!busy && n < 5000) begin
        cyc();
        n++;
      end
      chk("auto_period", n, RP);
    end
`else
    cyc();
    chk("upd_in_reset_ignored", busy, 0);

    do_frame(32'hA5A5A5A5, 128'h0123456789ABCDEF0123456789ABCDEF, 0, 1'b0);
    do_frame($urandom, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b1);
    do_frame($urandom, {$urandom, $urandom, $urandom, $urandom}, 3, 1'b0);

    // Abort at bit 80, then a fresh frame must be complete.
    sevseg_data = $urandom;
    screen_data = {$urandom, $urandom, $urandom, $urandom};
    pulse();
    n = 0;
    while (nb != 80 && n < 3000) begin
      cyc();
      n++;
    end
    chk("reach_bit80", nb, 80);
    reset = 1'b1;
    cyc();
    chk("abort_cs_n", ser_cs_n, 1);
    chk("abort_busy", busy, 0);
    chk("abort_fc", frame_count, 0);
    reset = 1'b0;
    fc_model = '0;
    got_q.delete(); bits_q.delete(); unst_q.delete(); len_q.delete();
    exp_q.delete(); exp_len_q.delete();
    cyc();
    do_frame($urandom, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0);

    for (int it = 0; it < 6; it++) begin
      do_frame($urandom, {$urandom, $urandom, $urandom, $urandom},
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
               1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 15)) cyc();
    end

    // Fast divider: preload the counter to its top value and check the wrap.
    force dut_b.frame_count_q = 16'hFFFF;
    cyc();
    release dut_b.frame_count_q;
    cyc();
    chk("b_preload", b_frame_count, 16'hFFFF);
    b_update = 1'b1;
    cyc();
    b_update = 1'b0;
    n = 0;
    while (b_busy && n < 1000) begin
      n++;
      cyc();
    end
    chk("b_busy_len", n, 322);
    chk("b_wrap", b_frame_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
